id_stage_hz: RTL and testbench

Parametrised decode stage for the five-stage pipelined CPU, sitting between the IF/ID and ID/EX boundaries. It contains a register file with write-through bypass, main control decode, immediate extension, and the ID/EX pipeline register. Over the previous decode stage it adds:

- configurable data width and register count;
- a valid bit;
- load-use hazard detection with bubble insertion and a stall request to IF;
- a flush input for taken branches;
- an illegal-opcode flag;
- a stall counter.

---
 rtl/cpu_pkg.sv | 76 +++++++
 rtl/id_stage_hz_if.sv | 23 ++
 rtl/id_regfile.sv | 42 ++++
 rtl/id_stage_hz.sv | 142 ++++++++++++++
 tb/tb_id_stage_hz.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the five-stage CPU: opcodes, control-field
// layout, ALUOp encodings and the main control decoder.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam int WB_W  = 2;
   localparam int MEM_W = 3;
   localparam int EX_W  = 4;

   // Bit positions inside the WB {MemtoReg, RegWrite}, MEM {MemWrite, MemRead,
   // Branch} and EX {ALUSrc, ALUOp[1:0], RegDst} bundles.
   localparam int WB_REGWRITE  = 0;
   localparam int WB_MEMTOREG  = 1;
   localparam int MEM_BRANCH   = 0;
   localparam int MEM_READ     = 1;
   localparam int MEM_WRITE    = 2;
   localparam int EX_REGDST    = 0;
   localparam int EX_ALUOP_LSB = 1;
   localparam int EX_ALUSRC    = 3;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic [WB_W-1:0]  wb;
      logic [MEM_W-1:0] mem;
      logic [EX_W-1:0]  ex;
      logic             illegal;
      logic             uses_rt;
   } ctrl_t;

   function automatic ctrl_t decode_op(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.wb[WB_REGWRITE]           = 1'b1;
            c.ex[EX_ALUOP_LSB +: 2]     = ALUOP_FUNCT;
            c.ex[EX_REGDST]             = 1'b1;
            c.uses_rt                   = 1'b1;
         end
         OP_LW: begin
            c.wb[WB_REGWRITE]           = 1'b1;
            c.wb[WB_MEMTOREG]           = 1'b1;
            c.mem[MEM_READ]             = 1'b1;
            c.ex[EX_ALUSRC]             = 1'b1;
            c.ex[EX_ALUOP_LSB +: 2]     = ALUOP_ADD;
         end
         OP_SW: begin
            c.mem[MEM_WRITE]            = 1'b1;
            c.ex[EX_ALUSRC]             = 1'b1;
            c.ex[EX_ALUOP_LSB +: 2]     = ALUOP_ADD;
            c.uses_rt                   = 1'b1;
         end
         OP_BEQ: begin
            c.mem[MEM_BRANCH]           = 1'b1;
            c.ex[EX_ALUOP_LSB +: 2]     = ALUOP_SUB;
            c.uses_rt                   = 1'b1;
         end
         OP_ADDI: begin
            c.wb[WB_REGWRITE]           = 1'b1;
            c.ex[EX_ALUSRC]             = 1'b1;
            c.ex[EX_ALUOP_LSB +: 2]     = ALUOP_ADD;
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_stage_hz_if.sv
// IF/ID and write-back bus feeding the decode stage; the front end drives it
// through the master modport, the decode side observes it through slave.
interface id_stage_hz_if #(
   parameter int DATA_W  = 32,
   parameter int REG_CNT = 32,
   parameter int RA_W    = $clog2(REG_CNT)
);
   logic              valid;
   logic [31:0]       instr;
   logic [DATA_W-1:0] next_pc;
   logic              flush;
   logic              wb_en;
   logic [RA_W-1:0]   wb_reg;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output valid, instr, next_pc, flush, wb_en, wb_reg, wb_data
   );

   modport slave (
      input valid, instr, next_pc, flush, wb_en, wb_reg, wb_data
   );
endinterface

// File: rtl/id_regfile.sv
// Architectural register file: two read ports with write-through bypass,
// one write port, register 0 hard-wired to zero.
module id_regfile #(
   parameter int DATA_W  = 32,
   parameter int REG_CNT = 32,
   parameter int RA_W    = $clog2(REG_CNT)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [RA_W-1:0]   i_ra1,
   input  logic [RA_W-1:0]   i_ra2,
   output logic [DATA_W-1:0] o_rd1,
   output logic [DATA_W-1:0] o_rd2,
   input  logic              i_we,
   input  logic [RA_W-1:0]   i_wa,
   input  logic [DATA_W-1:0] i_wd
);
   logic [DATA_W-1:0]         r_mem [REG_CNT];
   logic [1:0][RA_W-1:0]      w_ra;
   logic [1:0][DATA_W-1:0]    w_rd;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < REG_CNT; i++) r_mem[i] <= '0;
      end else if (i_we && i_wa != '0) begin
         r_mem[i_wa] <= i_wd;
      end
   end

   assign w_ra[0] = i_ra1;
   assign w_ra[1] = i_ra2;

   // A same-cycle write is forwarded so WB never needs an extra stall.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      assign w_rd[gi] = (w_ra[gi] == '0)               ? '0   :
                        (i_we && i_wa == w_ra[gi])     ? i_wd :
                                                         r_mem[w_ra[gi]];
   end

   assign o_rd1 = w_rd[0];
   assign o_rd2 = w_rd[1];
endmodule

// File: rtl/id_stage_hz.sv
// Decode stage: control decode, immediate extension, register read, load-use
// hazard detection with bubble insertion, and the ID/EX pipeline register.
module id_stage_hz
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_CNT = 32,
   parameter int CNT_W   = 16,
   parameter int RA_W    = $clog2(REG_CNT)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [31:0]       i_instr,
   input  logic [DATA_W-1:0] i_next_pc,
   input  logic              i_flush,
   input  logic              i_wb_en,
   input  logic [RA_W-1:0]   i_wb_reg,
   input  logic [DATA_W-1:0] i_wb_data,
   output logic              o_stall,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_next_pc,
   output logic [DATA_W-1:0] o_read_data1,
   output logic [DATA_W-1:0] o_read_data2,
   output logic [DATA_W-1:0] o_imm,
   output logic [RA_W-1:0]   o_tar_reg,
   output logic [RA_W-1:0]   o_des_reg,
   output logic [WB_W-1:0]   o_WB_control,
   output logic [MEM_W-1:0]  o_MEM_control,
   output logic [EX_W-1:0]   o_EX_control,
   output logic              o_illegal,
   output logic [CNT_W-1:0]  o_stall_cnt
);
   logic [5:0]        w_opcode;
   logic [RA_W-1:0]   w_rs;
   logic [RA_W-1:0]   w_rt;
   logic [RA_W-1:0]   w_rd;
   logic [DATA_W-1:0] w_imm;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   ctrl_t             w_ctrl;
   logic              w_hz;
   logic              w_bubble;

   logic              r_valid;
   logic [DATA_W-1:0] r_next_pc;
   logic [DATA_W-1:0] r_rd1;
   logic [DATA_W-1:0] r_rd2;
   logic [DATA_W-1:0] r_imm;
   logic [RA_W-1:0]   r_tar;
   logic [RA_W-1:0]   r_des;
   logic [WB_W-1:0]   r_wb;
   logic [MEM_W-1:0]  r_mem;
   logic [EX_W-1:0]   r_ex;
   logic              r_illegal;
   logic [CNT_W-1:0]  r_stall_cnt;

   // Register fields are taken modulo REG_CNT (truncate or zero-extend).
   assign w_opcode = i_instr[31:26];
   assign w_rs     = RA_W'(i_instr[25:21]);
   assign w_rt     = RA_W'(i_instr[20:16]);
   assign w_rd     = RA_W'(i_instr[15:11]);
   assign w_imm    = DATA_W'($signed(i_instr[15:0]));
   assign w_ctrl   = decode_op(w_opcode);

   id_regfile #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT),
      .RA_W    (RA_W)
   ) u_regfile (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_ra1 (w_rs),
      .i_ra2 (w_rt),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2),
      .i_we  (i_wb_en),
      .i_wa  (i_wb_reg),
      .i_wd  (i_wb_data)
   );

   // rt only matters as a source for R-type, sw and beq; for lw/addi it is a destination.
   assign w_hz = i_valid & r_valid & r_mem[MEM_READ] & (r_tar != '0) &
                 ((r_tar == w_rs) | ((r_tar == w_rt) & w_ctrl.uses_rt));

   assign o_stall  = w_hz & ~i_flush;
   assign w_bubble = i_flush | w_hz | ~i_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid     <= 1'b0;
         r_next_pc   <= '0;
         r_rd1       <= '0;
         r_rd2       <= '0;
         r_imm       <= '0;
         r_tar       <= '0;
         r_des       <= '0;
         r_wb        <= '0;
         r_mem       <= '0;
         r_ex        <= '0;
         r_illegal   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         // Data fields always follow decode so bubbles carry deterministic values.
         r_next_pc <= i_next_pc;
         r_rd1     <= w_rd1;
         r_rd2     <= w_rd2;
         r_imm     <= w_imm;
         r_tar     <= w_rt;
         r_des     <= w_rd;
         if (w_bubble) begin
            r_valid   <= 1'b0;
            r_wb      <= '0;
            r_mem     <= '0;
            r_ex      <= '0;
            r_illegal <= 1'b0;
         end else begin
            r_valid   <= 1'b1;
            r_wb      <= w_ctrl.wb;
            r_mem     <= w_ctrl.mem;
            r_ex      <= w_ctrl.ex;
            r_illegal <= w_ctrl.illegal;
         end
         if (o_stall && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign o_valid       = r_valid;
   assign o_next_pc     = r_next_pc;
   assign o_read_data1  = r_rd1;
   assign o_read_data2  = r_rd2;
   assign o_imm         = r_imm;
   assign o_tar_reg     = r_tar;
   assign o_des_reg     = r_des;
   assign o_WB_control  = r_wb;
   assign o_MEM_control = r_mem;
   assign o_EX_control  = r_ex;
   assign o_illegal     = r_illegal;
   assign o_stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: directed hazard/bypass scenarios followed by random
// instruction streams, all checked against a cycle-level behavioural model.
module tb_id_stage_hz;
   localparam int DATA_W  = 32;
   localparam int REG_CNT = 32;
   localparam int CNT_W   = 3;
   localparam int RA_W    = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_stage_hz_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) bus ();

   logic              o_stall, o_valid, o_illegal;
   logic [DATA_W-1:0] o_next_pc, o_read_data1, o_read_data2, o_imm;
   logic [RA_W-1:0]   o_tar_reg, o_des_reg;
   logic [1:0]        o_WB_control;
   logic [2:0]        o_MEM_control;
   logic [3:0]        o_EX_control;
   logic [CNT_W-1:0]  o_stall_cnt;

   id_stage_hz #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .CNT_W(CNT_W)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_valid       (bus.valid),
      .i_instr       (bus.instr),
      .i_next_pc     (bus.next_pc),
      .i_flush       (bus.flush),
      .i_wb_en       (bus.wb_en),
      .i_wb_reg      (bus.wb_reg),
      .i_wb_data     (bus.wb_data),
      .o_stall       (o_stall),
      .o_valid       (o_valid),
      .o_next_pc     (o_next_pc),
      .o_read_data1  (o_read_data1),
      .o_read_data2  (o_read_data2),
      .o_imm         (o_imm),
      .o_tar_reg     (o_tar_reg),
      .o_des_reg     (o_des_reg),
      .o_WB_control  (o_WB_control),
      .o_MEM_control (o_MEM_control),
      .o_EX_control  (o_EX_control),
      .o_illegal     (o_illegal),
      .o_stall_cnt   (o_stall_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: architectural registers plus expected ID/EX contents.
   logic [DATA_W-1:0] m_regs [REG_CNT];
   logic              m_valid, m_ill;
   logic [1:0]        m_wb;
   logic [2:0]        m_mem;
   logic [3:0]        m_ex;
   logic [DATA_W-1:0] m_pc, m_rd1, m_rd2, m_imm;
   logic [4:0]        m_tar, m_des;
   int                m_cnt;
   logic              last_stall;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Control bundle per opcode, written straight from the encoding table.
   function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'b000000: return 9'b01_000_0101;
         6'b100011: return 9'b11_010_1000;
         6'b101011: return 9'b00_100_1000;
         6'b000100: return 9'b00_001_0010;
         6'b001000: return 9'b01_000_1000;
         default:   return 9'b0;
      endcase
   endfunction

   function automatic bit ref_legal(input logic [5:0] op);
      return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h08;
   endfunction

   function automatic logic [DATA_W-1:0] ref_read(input logic [4:0] a);
      if (a == 0) return '0;
      if (bus.wb_en && bus.wb_reg == a) return bus.wb_data;
      return m_regs[a];
   endfunction

   function automatic logic [31:0] r_type(input int rs, input int rt, input int rd);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < REG_CNT; i++) m_regs[i] = '0;
      m_valid = 0; m_ill = 0; m_wb = 0; m_mem = 0; m_ex = 0;
      m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_tar = 0; m_des = 0; m_cnt = 0;
   endtask

   // One clock: check o_stall before the edge, advance the model, check ID/EX after.
   task automatic cycle(input string tag);
      logic [5:0]        op;
      logic [4:0]        rs, rt, rd;
      bit                uses_rt, hz, exp_stall, bubble;
      logic [8:0]        c;
      logic [DATA_W-1:0] rd1, rd2;
      #1;
      op = bus.instr[31:26];
      rs = bus.instr[25:21];
      rt = bus.instr[20:16];
      rd = bus.instr[15:11];
      uses_rt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
      hz = bus.valid && m_valid && m_mem[1] && m_tar != 0 &&
           (m_tar == rs || (m_tar == rt && uses_rt));
      exp_stall = hz && !bus.flush;
      check({tag, ":stall"}, 64'(o_stall), 64'(exp_stall));
      last_stall = o_stall;
      rd1 = ref_read(rs);
      rd2 = ref_read(rt);
      c = ref_ctrl(op);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (bus.wb_en && bus.wb_reg != 0) m_regs[bus.wb_reg] = bus.wb_data;
         bubble  = bus.flush || hz || !bus.valid;
         m_valid = !bubble;
         m_wb    = bubble ? 2'b0 : c[8:7];
         m_mem   = bubble ? 3'b0 : c[6:4];
         m_ex    = bubble ? 4'b0 : c[3:0];
         m_ill   = bubble ? 1'b0 : !ref_legal(op);
         m_pc    = bus.next_pc;
         m_rd1   = rd1;
         m_rd2   = rd2;
         m_imm   = {{16{bus.instr[15]}}, bus.instr[15:0]};
         m_tar   = rt;
         m_des   = rd;
         if (exp_stall && m_cnt < (2**CNT_W) - 1) m_cnt++;
      end
      #1;
      check({tag, ":valid"}, 64'(o_valid), 64'(m_valid));
      check({tag, ":wb"},    64'(o_WB_control), 64'(m_wb));
      check({tag, ":mem"},   64'(o_MEM_control), 64'(m_mem));
      check({tag, ":ex"},    64'(o_EX_control), 64'(m_ex));
      check({tag, ":ill"},   64'(o_illegal), 64'(m_ill));
      check({tag, ":pc"},    64'(o_next_pc), 64'(m_pc));
      check({tag, ":rd1"},   64'(o_read_data1), 64'(m_rd1));
      check({tag, ":rd2"},   64'(o_read_data2), 64'(m_rd2));
      check({tag, ":imm"},   64'(o_imm), 64'(m_imm));
      check({tag, ":tar"},   64'(o_tar_reg), 64'(m_tar));
      check({tag, ":des"},   64'(o_des_reg), 64'(m_des));
      check({tag, ":cnt"},   64'(o_stall_cnt), 64'(m_cnt));
      $display("[TB] %-10s instr=%08h v=%0d fl=%0d stall=%0d -> valid=%0d cnt=%0d",
               tag, bus.instr, bus.valid, bus.flush, last_stall, o_valid, o_stall_cnt);
   endtask

   task automatic issue(input string tag, input logic [31:0] instr);
      bus.instr   = instr;
      bus.next_pc = bus.next_pc + 4;
      cycle(tag);
   endtask

   initial begin
      model_reset();
      last_stall  = 0;
      rst         = 1;
      bus.valid   = 1;
      bus.instr   = r_type(1, 2, 3);
      bus.next_pc = 32'h100;
      bus.flush   = 0;
      bus.wb_en   = 0;
      bus.wb_reg  = 0;
      bus.wb_data = 0;
      @(posedge clk);
      cycle("reset");
      check("reset_valid", 64'(o_valid), 64'd0);
      check("reset_cnt", 64'(o_stall_cnt), 64'd0);
      rst = 0;

      // Write-through on the register being read, then the register-0 case.
      bus.wb_en = 1; bus.wb_reg = 5; bus.wb_data = 32'hDEAD_BEEF;
      issue("wt5", r_type(5, 0, 3));
      check("wt5_rd1", 64'(o_read_data1), 64'hDEAD_BEEF);
      check("wt5_ex", 64'(o_EX_control), 64'b0101);
      bus.wb_reg = 0; bus.wb_data = 32'h1234_5678;
      issue("wt0", r_type(0, 0, 3));
      check("wt0_rd1", 64'(o_read_data1), 64'd0);
      bus.wb_en = 0;

      // Load-use: lw $4 then add $6,$4,$2, held while stalled.
      issue("lw4", i_type(6'h23, 1, 4, 16'd8));
      issue("add_st", r_type(4, 2, 6));
      check("lu_stall", 64'(last_stall), 64'd1);
      check("lu_bubble", 64'(o_valid), 64'd0);
      cycle("add_go");
      check("lu_issue", 64'(o_valid), 64'd1);
      check("lu_cnt", 64'(o_stall_cnt), 64'd1);

      issue("lw4b", i_type(6'h23, 1, 4, 16'd0));
      issue("addi_rs", i_type(6'h08, 4, 7, 16'd1));
      check("rs_stall", 64'(last_stall), 64'd1);
      cycle("addi_go");
      issue("lw4c", i_type(6'h23, 1, 4, 16'd0));
      issue("addi_rt", i_type(6'h08, 9, 4, 16'd1));
      check("rt_nostall", 64'(last_stall), 64'd0);
      issue("lw0", i_type(6'h23, 1, 0, 16'd0));
      issue("add_r0", r_type(0, 0, 5));
      check("r0_nostall", 64'(last_stall), 64'd0);

      // Flush takes priority over a pending load-use stall.
      issue("lw4d", i_type(6'h23, 1, 4, 16'd0));
      bus.flush = 1;
      issue("flush", r_type(4, 2, 6));
      check("fl_stall", 64'(last_stall), 64'd0);
      check("fl_bubble", 64'(o_valid), 64'd0);
      check("fl_cnt", 64'(o_stall_cnt), 64'd2);
      bus.flush = 0;

      issue("illegal", {6'h3f, 26'h0123456});
      check("ill_flag", 64'(o_illegal), 64'd1);
      check("ill_valid", 64'(o_valid), 64'd1);
      issue("imm", i_type(6'h08, 1, 2, 16'h8000));
      check("imm_sext", 64'(o_imm), 64'hFFFF_8000);

      // Reset landing in the middle of a stall.
      issue("lw4e", i_type(6'h23, 1, 4, 16'd0));
      rst = 1;
      issue("rst_stall", r_type(4, 2, 6));
      rst = 0;
      cycle("post_rst");
      check("post_rst_stall", 64'(last_stall), 64'd0);

      // Random streams over a small register window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         logic [5:0] ops [6];
         logic [5:0] op;
         ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h3f};
         op = ops[$urandom_range(5)];
         if (!last_stall) begin
            if (op == 6'h00) bus.instr = r_type($urandom_range(7), $urandom_range(7), $urandom_range(7));
            else             bus.instr = i_type(op, $urandom_range(7), $urandom_range(7), 16'($urandom));
            bus.next_pc = bus.next_pc + 4;
         end
         bus.valid   = ($urandom_range(9) != 0);
         bus.flush   = ($urandom_range(9) == 0);
         bus.wb_en   = $urandom_range(1);
         bus.wb_reg  = 5'($urandom_range(7));
         bus.wb_data = $urandom;
         cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
